// File: rtl/mc_control_seq.sv
// mc_control_seq: microcoded control sequencer for a small register machine.
// A single FSM walks each instruction through fetch, decode, execute, memory
// and write-back states. The control word c is decoded from the current state
// in every cycle the sequencer advances and is forced to zero otherwise.
//
// Handshake: there is no valid/ready pair here. The sequencer advances on
// w_adv = run | (step when stepping is enabled). opcode_in and flags_reg are
// sampled in the ID cycle that advances; everything the later states need is
// captured at that point, so opcode_in may change once ID has been left.
module mc_control_seq #(
  parameter int CW      = 24,
  parameter int CNTW    = 16,
  parameter int STEP_EN = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            run,
  input  logic            step,
  input  logic [26:0]     opcode_in,
  input  logic [3:0]      flags_reg,
  output logic [CW:1]     c,
  output logic [3:0]      state_o,
  output logic            instr_done,
  output logic [CNTW-1:0] retired,
  output logic            illegal_op
);

  typedef enum logic [3:0] {
    S_IF      = 4'd0,
    S_ID      = 4'd1,
    S_EX_ALU  = 4'd2,
    S_EX_ADDR = 4'd3,
    S_EX_JUMP = 4'd4,
    S_EX_LOAD = 4'd5,
    S_EX_LOADI= 4'd6,
    S_EX_MOVE = 4'd7,
    S_EX_LIR  = 4'd8,
    S_EX_SWAP = 4'd9,
    S_MEM_RD  = 4'd10,
    S_MEM_WR  = 4'd11,
    S_WB_ALU  = 4'd12,
    S_WB_LOAD = 4'd13
  } state_t;

  localparam logic            LP_STEP = (STEP_EN != 0);
  localparam logic [CNTW-1:0] LP_ONE  = {{(CNTW-1){1'b0}}, 1'b1};

  // Architectural state.
  state_t          r_state;
  logic [CNTW-1:0] r_retired;
  logic            r_illegal;

  // Instruction context captured in ID for the later states.
  logic [1:0]      r_rx;
  logic [1:0]      r_ry;
  logic            r_c12;
  logic            r_c13;
  logic            r_loadf;
  logic            r_store;
  logic            r_storef;
  logic            r_cmp;

  // Combinational decode.
  logic            w_adv;
  logic [22:0]     w_op;
  logic            w_legal;
  logic [22:0]     w_opc;
  logic [1:0]      w_rx_in;
  logic [1:0]      w_ry_in;
  logic            w_swap_id;
  logic            w_c12_in;
  logic            w_c13_in;
  logic            w_z;
  logic            w_n;
  logic            w_taken;
  logic            w_done;
  state_t          w_next;
  logic [CW:1]     w_c;
  logic            w_unused_bits;

  assign w_adv   = run | (LP_STEP & step);

  // A zero or multi-hot opcode is executed as NOOP (bit 0).
  assign w_op    = opcode_in[22:0];
  assign w_legal = (w_op != 23'd0) && ((w_op & (w_op - 23'd1)) == 23'd0);
  assign w_opc   = w_legal ? w_op : 23'd1;
  assign w_rx_in = opcode_in[26:25];
  assign w_ry_in = opcode_in[24:23];

  // MOVE, LOADF, STORE and STOREF read their operands in swapped order.
  assign w_swap_id = w_opc[5] | w_opc[12] | w_opc[13] | w_opc[14];

  // ALU function select bits used during EX_ALU / EX_ADDR.
  assign w_c12_in = w_opc[17] | w_opc[14] | w_opc[12] | w_opc[10] | w_opc[9] |
                    w_opc[8]  | w_opc[7]  | w_opc[5]  | w_opc[4]  | w_opc[2];
  assign w_c13_in = w_opc[17] | w_opc[16] | w_opc[10] | w_opc[9];

  // Branch resolution uses the flags present in the ID cycle.
  assign w_z     = flags_reg[0];
  assign w_n     = flags_reg[1];
  assign w_taken = (w_opc[19] &  w_z) |
                   (w_opc[20] & ~w_z) |
                   (w_opc[21] & ~w_z & ~w_n) |
                   (w_opc[22] & ~w_n);

  // Overflow/carry flags and the opcodes with no private decode are not
  // needed by the sequencer itself.
  assign w_unused_bits = &{1'b0, flags_reg[3:2], w_opc[0], w_opc[1], w_opc[3]};

  // Next-state selection for every state; unreachable codes return to IF.
  always_comb begin
    w_next = S_IF;
    case (r_state)
      S_IF: w_next = S_ID;
      S_ID: begin
        if (w_opc[5])                                          w_next = S_EX_MOVE;
        else if (w_opc[6])                                     w_next = S_EX_LOADI;
        else if (w_opc[7] | w_opc[9] | w_opc[15] | w_opc[16] | w_opc[17])
                                                               w_next = S_EX_ALU;
        else if (w_opc[8] | w_opc[10])                         w_next = S_EX_ADDR;
        else if (w_opc[11] | w_opc[12] | w_opc[13])            w_next = S_EX_LOAD;
        else if (w_opc[14])                                    w_next = S_EX_SWAP;
        else if (w_opc[18] | w_taken)                          w_next = S_EX_JUMP;
        else                                                   w_next = S_IF;
      end
      S_EX_ALU:   w_next = r_loadf ? S_MEM_RD : (r_cmp ? S_IF : S_WB_ALU);
      S_EX_ADDR:  w_next = S_WB_ALU;
      S_EX_JUMP:  w_next = S_IF;
      S_EX_LOAD:  w_next = r_loadf ? S_WB_ALU : (r_store ? S_MEM_WR : S_MEM_RD);
      S_EX_LOADI: w_next = r_storef ? S_MEM_WR : S_WB_ALU;
      S_EX_MOVE:  w_next = S_WB_ALU;
      S_EX_LIR:   w_next = S_EX_ALU;
      S_EX_SWAP:  w_next = S_EX_LOADI;
      S_MEM_RD:   w_next = S_WB_LOAD;
      S_MEM_WR:   w_next = S_IF;
      S_WB_ALU:   w_next = r_loadf ? S_EX_LIR : S_IF;
      S_WB_LOAD:  w_next = S_IF;
      default:    w_next = S_IF;
    endcase
  end

  // An instruction retires on the advancing edge that leaves its last state.
  assign w_done = w_adv & (w_next == S_IF) & (r_state != S_IF);

  // State register, retirement counter, sticky illegal flag, ID capture.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IF;
      r_retired <= '0;
      r_illegal <= 1'b0;
      r_rx      <= 2'd0;
      r_ry      <= 2'd0;
      r_c12     <= 1'b0;
      r_c13     <= 1'b0;
      r_loadf   <= 1'b0;
      r_store   <= 1'b0;
      r_storef  <= 1'b0;
      r_cmp     <= 1'b0;
    end else if (w_adv) begin
      r_state <= w_next;
      if (r_state == S_ID) begin
        r_rx     <= w_rx_in;
        r_ry     <= w_ry_in;
        r_c12    <= w_c12_in;
        r_c13    <= w_c13_in;
        r_loadf  <= w_opc[12];
        r_store  <= w_opc[13];
        r_storef <= w_opc[14];
        r_cmp    <= w_opc[17];
        if (!w_legal) begin
          r_illegal <= 1'b1;
        end
      end
      if (w_done) begin
        r_retired <= r_retired + LP_ONE;
      end
    end
  end

  // Control word decode; all-zero whenever the sequencer holds or is in reset.
  always_comb begin
    w_c = '0;
    if (w_adv && !reset) begin
      case (r_state)
        S_IF: begin
          w_c[3]  = 1'b1;
          w_c[12] = 1'b1;
          w_c[16] = 1'b1;
          w_c[20] = 1'b1;
          w_c[22] = 1'b1;
        end
        S_ID: begin
          w_c[3]  = 1'b1;
          w_c[11] = 1'b1;
          w_c[12] = 1'b1;
          w_c[15] = 1'b1;
          w_c[22] = 1'b1;
          if (w_swap_id) begin
            {w_c[4], w_c[5], w_c[6], w_c[7]} = {w_ry_in, w_rx_in};
          end else begin
            {w_c[4], w_c[5], w_c[6], w_c[7]} = {w_rx_in, w_ry_in};
          end
        end
        S_EX_ALU: begin
          w_c[12] = r_c12;
          w_c[13] = r_c13;
          w_c[14] = 1'b1;
          w_c[21] = 1'b1;
          w_c[22] = 1'b1;
          w_c[24] = 1'b1;
        end
        S_EX_ADDR: begin
          w_c[12] = r_c12;
          w_c[13] = r_c13;
          w_c[14] = 1'b1;
          w_c[22] = 1'b1;
          w_c[24] = 1'b1;
        end
        S_EX_LOAD: begin
          w_c[12] = 1'b1;
          w_c[14] = 1'b1;
          w_c[19] = 1'b1;
          w_c[22] = 1'b1;
          w_c[24] = 1'b1;
        end
        S_EX_MOVE: begin
          w_c[12] = 1'b1;
          w_c[14] = 1'b1;
          w_c[19] = 1'b1;
          w_c[20] = 1'b1;
          w_c[22] = 1'b1;
          w_c[24] = 1'b1;
        end
        S_EX_LOADI: begin
          w_c[12] = 1'b1;
          w_c[19] = 1'b1;
          w_c[22] = 1'b1;
          w_c[24] = 1'b1;
        end
        S_EX_JUMP: begin
          w_c[2] = 1'b1;
          w_c[3] = 1'b1;
        end
        S_EX_LIR: begin
          w_c[11]         = 1'b1;
          {w_c[4], w_c[5]} = r_rx;
        end
        S_EX_SWAP: begin
          w_c[11]          = 1'b1;
          w_c[15]          = 1'b1;
          {w_c[6], w_c[7]} = r_rx;
          {w_c[4], w_c[5]} = r_ry;
        end
        S_MEM_RD: begin
          w_c[23] = 1'b1;
        end
        S_MEM_WR: begin
          w_c[17] = 1'b1;
        end
        S_WB_ALU: begin
          w_c[10]          = 1'b1;
          {w_c[8], w_c[9]} = r_rx;
        end
        S_WB_LOAD: begin
          w_c[10]          = 1'b1;
          w_c[18]          = 1'b1;
          {w_c[8], w_c[9]} = r_rx;
        end
        default: begin
          w_c = '0;
        end
      endcase
    end
  end

  assign c          = w_c;
  assign state_o    = r_state;
  assign instr_done = w_done & ~reset;
  assign retired    = r_retired;
  assign illegal_op = r_illegal;

endmodule

// File: tb/tb_mc_control_seq.sv
// Testbench for mc_control_seq: state walks, control words, stepping,
// illegal opcodes, reset mid-instruction and retirement counter wrap.
module tb_mc_control_seq;

  localparam int CW   = 24;
  localparam int CNTW = 8;
  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  logic            clock = 1'b0;
  logic            reset;
  logic            run;
  logic            step;
  logic [26:0]     opcode_in;
  logic [3:0]      flags_reg;
  logic [CW:1]     c;
  logic [3:0]      state_o;
  logic            instr_done;
  logic [CNTW-1:0] retired;
  logic            illegal_op;

  int              n_checks = 0;
  int              n_errors = 0;
  logic [3:0]      exp_q[$];
  logic [CNTW-1:0] exp_retired = '0;

  mc_control_seq #(.CW(CW), .CNTW(CNTW), .STEP_EN(1)) dut (
    .clock      (clock),
    .reset      (reset),
    .run        (run),
    .step       (step),
    .opcode_in  (opcode_in),
    .flags_reg  (flags_reg),
    .c          (c),
    .state_o    (state_o),
    .instr_done (instr_done),
    .retired    (retired),
    .illegal_op (illegal_op)
  );

  // Clock and watchdog.
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [26:0] mk_op(int idx, logic [1:0] rx, logic [1:0] ry);
    logic [26:0] o;
    o         = '0;
    o[idx]    = 1'b1;
    o[26:25]  = rx;
    o[24:23]  = ry;
    return o;
  endfunction

  // Expected state sequence of one instruction, from fetch to its last state.
  function automatic void push_path(int idx, logic [3:0] fl);
    logic z;
    logic n;
    z = fl[0];
    n = fl[1];
    exp_q.push_back(4'd0);
    exp_q.push_back(4'd1);
    case (idx)
      5:             begin exp_q.push_back(4'd7); exp_q.push_back(4'd12); end
      6:             begin exp_q.push_back(4'd6); exp_q.push_back(4'd12); end
      7, 9, 15, 16:  begin exp_q.push_back(4'd2); exp_q.push_back(4'd12); end
      8, 10:         begin exp_q.push_back(4'd3); exp_q.push_back(4'd12); end
      17:            exp_q.push_back(4'd2);
      11:            begin exp_q.push_back(4'd5); exp_q.push_back(4'd10); exp_q.push_back(4'd13); end
      12: begin
        exp_q.push_back(4'd5);  exp_q.push_back(4'd12); exp_q.push_back(4'd8);
        exp_q.push_back(4'd2);  exp_q.push_back(4'd10); exp_q.push_back(4'd13);
      end
      13:            begin exp_q.push_back(4'd5); exp_q.push_back(4'd11); end
      14:            begin exp_q.push_back(4'd9); exp_q.push_back(4'd6); exp_q.push_back(4'd11); end
      18:            exp_q.push_back(4'd4);
      19:            if (z)       exp_q.push_back(4'd4);
      20:            if (!z)      exp_q.push_back(4'd4);
      21:            if (!z && !n) exp_q.push_back(4'd4);
      22:            if (!n)      exp_q.push_back(4'd4);
      default: ;
    endcase
  endfunction

  // Expected control word for an advancing cycle in state st.
  function automatic logic [24:1] exp_cw(logic [3:0] st, logic [26:0] op);
    logic [24:1] w;
    logic [1:0]  rx;
    logic [1:0]  ry;
    w  = '0;
    rx = op[26:25];
    ry = op[24:23];
    case (st)
      4'd0: begin w[3] = 1; w[12] = 1; w[16] = 1; w[20] = 1; w[22] = 1; end
      4'd1: begin
        w[3] = 1; w[11] = 1; w[12] = 1; w[15] = 1; w[22] = 1;
        if (op[5] | op[12] | op[13] | op[14]) {w[4], w[5], w[6], w[7]} = {ry, rx};
        else                                  {w[4], w[5], w[6], w[7]} = {rx, ry};
      end
      4'd2, 4'd3: begin
        w[12] = op[17] | op[14] | op[12] | op[10] | op[9] | op[8] | op[7] | op[5] | op[4] | op[2];
        w[13] = op[17] | op[16] | op[10] | op[9];
        w[14] = 1; w[22] = 1; w[24] = 1;
        if (st == 4'd2) w[21] = 1;
      end
      4'd4:  begin w[2] = 1; w[3] = 1; end
      4'd5:  begin w[12] = 1; w[14] = 1; w[19] = 1; w[22] = 1; w[24] = 1; end
      4'd6:  begin w[12] = 1; w[19] = 1; w[22] = 1; w[24] = 1; end
      4'd7:  begin w[12] = 1; w[14] = 1; w[19] = 1; w[20] = 1; w[22] = 1; w[24] = 1; end
      4'd8:  begin w[11] = 1; {w[4], w[5]} = rx; end
      4'd9:  begin w[11] = 1; w[15] = 1; {w[6], w[7]} = rx; {w[4], w[5]} = ry; end
      4'd10: w[23] = 1;
      4'd11: w[17] = 1;
      4'd12: begin w[10] = 1; {w[8], w[9]} = rx; end
      4'd13: begin w[10] = 1; w[18] = 1; {w[8], w[9]} = rx; end
      default: ;
    endcase
    return w;
  endfunction

  // Driver: free-run n NOOPs with no checking (used to preload the counter).
  task automatic run_noops(int n);
    run       = 1'b1;
    step      = 1'b0;
    opcode_in = mk_op(0, 2'd0, 2'd0);
    repeat (2 * n) @(posedge clock);
    #1;
    exp_retired = exp_retired + n[CNTW-1:0];
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    run       = 1'b1;
    step      = 1'b0;
    opcode_in = mk_op(7, 2'd1, 2'd2);
    flags_reg = 4'd0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_checks++; if (state_o !== 4'd0) begin n_errors++; $display("FAIL reset_state: got %0d expected 0", state_o); end
    n_checks++; if (c !== '0) begin n_errors++; $display("FAIL reset_c: got %h expected 0", c); end
    n_checks++; if (instr_done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b expected 0", instr_done); end
    n_checks++; if (retired !== '0) begin n_errors++; $display("FAIL reset_retired: got %0d expected 0", retired); end
    n_checks++; if (illegal_op !== 1'b0) begin n_errors++; $display("FAIL reset_illegal: got %b expected 0", illegal_op); end
    @(posedge clock); #1;
    reset = 1'b0;
    run   = 1'b0;
    exp_retired = '0;
  endtask

  // ADD, BRG taken / not taken and LOADF with hand-written state sequences.
  task automatic test_spec_paths();
    logic [26:0] op;
    logic [3:0]  s;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: begin op = mk_op(7, 2'd1, 2'd2);  flags_reg = 4'b0000; exp_q = '{4'd0, 4'd1, 4'd2, 4'd12}; end
        1: begin op = mk_op(21, 2'd0, 2'd3); flags_reg = 4'b0000; exp_q = '{4'd0, 4'd1, 4'd4}; end
        2: begin op = mk_op(21, 2'd0, 2'd3); flags_reg = 4'b0001; exp_q = '{4'd0, 4'd1}; end
        default: begin
          op = mk_op(12, 2'd3, 2'd1); flags_reg = 4'b0000;
          exp_q = '{4'd0, 4'd1, 4'd5, 4'd12, 4'd8, 4'd2, 4'd10, 4'd13};
        end
      endcase
      opcode_in = op;
      run       = 1'b1;
      while (exp_q.size() > 0) begin
        s = exp_q.pop_front();
        @(negedge clock);
        n_checks++; if (state_o !== s) begin n_errors++; $display("FAIL path%0d_state: got %0d expected %0d", k, state_o, s); end
        n_checks++; if (c !== exp_cw(s, op)) begin n_errors++; $display("FAIL path%0d_c st%0d: got %h expected %h", k, s, c, exp_cw(s, op)); end
        n_checks++; if (c[23] !== (s == 4'd10)) begin n_errors++; $display("FAIL path%0d_c23 st%0d: got %b", k, s, c[23]); end
        n_checks++; if (instr_done !== (exp_q.size() == 0)) begin n_errors++; $display("FAIL path%0d_done st%0d: got %b", k, s, instr_done); end
        @(posedge clock); #1;
      end
      exp_retired++;
      n_checks++; if (retired !== exp_retired) begin n_errors++; $display("FAIL path%0d_retired: got %0d expected %0d", k, retired, exp_retired); end
    end
    run = 1'b0;
  endtask

  // Every opcode twice, random registers and flags, scoreboarded per cycle.
  task automatic test_all_opcodes();
    logic [26:0] op;
    logic [3:0]  fl;
    logic [3:0]  s;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 23; i++) begin
        op = mk_op(i, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        fl = 4'($urandom_range(0, 15));
        push_path(i, fl);
        opcode_in = op;
        flags_reg = fl;
        run       = 1'b1;
        while (exp_q.size() > 0) begin
          s = exp_q.pop_front();
          @(negedge clock);
          n_checks++; if (state_o !== s) begin n_errors++; $display("FAIL op%0d_state: got %0d expected %0d", i, state_o, s); end
          n_checks++; if (c !== exp_cw(s, op)) begin n_errors++; $display("FAIL op%0d_c st%0d: got %h expected %h", i, s, c, exp_cw(s, op)); end
          n_checks++; if (instr_done !== (exp_q.size() == 0)) begin n_errors++; $display("FAIL op%0d_done st%0d: got %b", i, s, instr_done); end
          @(posedge clock); #1;
        end
        exp_retired++;
        n_checks++; if (retired !== exp_retired) begin n_errors++; $display("FAIL op%0d_retired: got %0d expected %0d", i, retired, exp_retired); end
      end
    end
    run = 1'b0;
  endtask

  // STORE single-stepped; no movement and zero control word between pulses.
  task automatic test_step();
    logic [26:0] op;
    logic [3:0]  seq[4];
    seq = '{4'd0, 4'd1, 4'd5, 4'd11};
    op  = mk_op(13, 2'd2, 2'd1);
    opcode_in = op;
    run       = 1'b0;
    for (int p = 0; p < 4; p++) begin
      step = 1'b0;
      repeat (4) begin
        @(negedge clock);
        n_checks++; if (state_o !== seq[p]) begin n_errors++; $display("FAIL step_hold%0d: got %0d expected %0d", p, state_o, seq[p]); end
        n_checks++; if (c !== '0) begin n_errors++; $display("FAIL step_c_idle%0d: got %h expected 0", p, c); end
        n_checks++; if (instr_done !== 1'b0) begin n_errors++; $display("FAIL step_done_idle%0d: got %b", p, instr_done); end
        @(posedge clock); #1;
      end
      step = 1'b1;
      @(negedge clock);
      n_checks++; if (c !== exp_cw(seq[p], op)) begin n_errors++; $display("FAIL step_c_pulse%0d: got %h expected %h", p, c, exp_cw(seq[p], op)); end
      n_checks++; if (instr_done !== (p == 3)) begin n_errors++; $display("FAIL step_done_pulse%0d: got %b", p, instr_done); end
      @(posedge clock); #1;
      step = 1'b0;
    end
    exp_retired++;
    @(negedge clock);
    n_checks++; if (state_o !== 4'd0) begin n_errors++; $display("FAIL step_end_state: got %0d expected 0", state_o); end
    n_checks++; if (retired !== exp_retired) begin n_errors++; $display("FAIL step_retired: got %0d expected %0d", retired, exp_retired); end
    @(posedge clock); #1;
  endtask

  // run and step together still advance exactly one state per clock.
  task automatic test_step_and_run();
    logic [3:0] s;
    opcode_in = mk_op(11, 2'd1, 2'd0);
    exp_q     = '{4'd0, 4'd1, 4'd5, 4'd10, 4'd13};
    run       = 1'b1;
    step      = 1'b1;
    while (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      @(negedge clock);
      n_checks++; if (state_o !== s) begin n_errors++; $display("FAIL runstep_state: got %0d expected %0d", state_o, s); end
      @(posedge clock); #1;
    end
    exp_retired++;
    n_checks++; if (retired !== exp_retired) begin n_errors++; $display("FAIL runstep_retired: got %0d expected %0d", retired, exp_retired); end
    run  = 1'b0;
    step = 1'b0;
  endtask

  // Zero and multi-hot opcodes run as NOOP and set the sticky flag.
  task automatic test_illegal();
    logic [26:0] ops[2];
    logic [3:0]  s;
    ops[0] = 27'h0;
    ops[1] = 27'h0000180;
    n_checks++; if (illegal_op !== 1'b0) begin n_errors++; $display("FAIL illegal_pre: got %b expected 0", illegal_op); end
    for (int k = 0; k < 2; k++) begin
      opcode_in = ops[k];
      run       = 1'b1;
      exp_q     = '{4'd0, 4'd1};
      while (exp_q.size() > 0) begin
        s = exp_q.pop_front();
        @(negedge clock);
        n_checks++; if (state_o !== s) begin n_errors++; $display("FAIL illegal%0d_state: got %0d expected %0d", k, state_o, s); end
        n_checks++; if (instr_done !== (exp_q.size() == 0)) begin n_errors++; $display("FAIL illegal%0d_done: got %b", k, instr_done); end
        @(posedge clock); #1;
      end
      exp_retired++;
      n_checks++; if (illegal_op !== 1'b1) begin n_errors++; $display("FAIL illegal%0d_flag: got %b expected 1", k, illegal_op); end
    end
    run_noops(2);
    n_checks++; if (illegal_op !== 1'b1) begin n_errors++; $display("FAIL illegal_sticky: got %b expected 1", illegal_op); end
    n_checks++; if (retired !== exp_retired) begin n_errors++; $display("FAIL illegal_retired: got %0d expected %0d", retired, exp_retired); end
    run   = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    n_checks++; if (illegal_op !== 1'b0) begin n_errors++; $display("FAIL illegal_cleared: got %b expected 0", illegal_op); end
    @(posedge clock); #1;
    reset = 1'b0;
    exp_retired = '0;
  endtask

  // Reset in MEM_RD of a LOAD with the counter at its maximum.
  task automatic test_reset_mid_instr();
    logic [26:0] op;
    run_noops(int'(CNT_MAX - exp_retired));
    n_checks++; if (retired !== CNT_MAX) begin n_errors++; $display("FAIL mid_preload: got %0d expected %0d", retired, CNT_MAX); end
    op        = mk_op(11, 2'd2, 2'd3);
    opcode_in = op;
    repeat (3) @(posedge clock);
    #2;
    n_checks++; if (state_o !== 4'd10) begin n_errors++; $display("FAIL mid_in_memrd: got %0d expected 10", state_o); end
    n_checks++; if (c !== exp_cw(4'd10, op)) begin n_errors++; $display("FAIL mid_c_memrd: got %h expected %h", c, exp_cw(4'd10, op)); end
    reset = 1'b1;
    #1;
    n_checks++; if (state_o !== 4'd0) begin n_errors++; $display("FAIL mid_rst_state: got %0d expected 0", state_o); end
    n_checks++; if (retired !== '0) begin n_errors++; $display("FAIL mid_rst_retired: got %0d expected 0", retired); end
    n_checks++; if (c !== '0) begin n_errors++; $display("FAIL mid_rst_c: got %h expected 0", c); end
    n_checks++; if (instr_done !== 1'b0) begin n_errors++; $display("FAIL mid_rst_done: got %b expected 0", instr_done); end
    @(posedge clock);
    @(negedge clock);
    n_checks++; if (c !== '0) begin n_errors++; $display("FAIL mid_rst_hold_c: got %h expected 0", c); end
    @(posedge clock); #1;
    reset       = 1'b0;
    exp_retired = '0;
    opcode_in   = mk_op(0, 2'd0, 2'd0);
    @(negedge clock);
    n_checks++; if (state_o !== 4'd0) begin n_errors++; $display("FAIL mid_first_fetch: got %0d expected 0", state_o); end
    n_checks++; if (c !== exp_cw(4'd0, opcode_in)) begin n_errors++; $display("FAIL mid_first_c: got %h expected %h", c, exp_cw(4'd0, opcode_in)); end
    @(posedge clock);
    @(negedge clock);
    n_checks++; if (state_o !== 4'd1) begin n_errors++; $display("FAIL mid_then_id: got %0d expected 1", state_o); end
    @(posedge clock); #1;
    exp_retired++;
    run = 1'b0;
  endtask

  // Counter wraps from its maximum to zero on the next retirement.
  task automatic test_wrap();
    run_noops(int'(CNT_MAX - exp_retired));
    n_checks++; if (retired !== CNT_MAX) begin n_errors++; $display("FAIL wrap_preload: got %0d expected %0d", retired, CNT_MAX); end
    opcode_in = mk_op(0, 2'd0, 2'd0);
    run       = 1'b1;
    @(negedge clock);
    n_checks++; if (instr_done !== 1'b0) begin n_errors++; $display("FAIL wrap_done_if: got %b expected 0", instr_done); end
    @(posedge clock);
    @(negedge clock);
    n_checks++; if (instr_done !== 1'b1) begin n_errors++; $display("FAIL wrap_done_id: got %b expected 1", instr_done); end
    @(posedge clock); #1;
    run = 1'b0;
    exp_retired = exp_retired + 1'b1;
    n_checks++; if (retired !== exp_retired) begin n_errors++; $display("FAIL wrap_value: got %0d expected %0d", retired, exp_retired); end
  endtask

  initial begin
    test_reset();
    test_spec_paths();
    test_all_opcodes();
    test_step();
    test_step_and_run();
    test_illegal();
    test_reset_mid_instr();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mc_control_seq.md
MC_CONTROL_SEQ -- requirements
Module: mc_control_seq

Interface
REQ-001 Parameter CW, default 24: control word width; SHALL be >=24; bits c[CW:25] are always 0.
REQ-002 Parameter CNTW, default 16: retired-instruction counter width.
REQ-003 Parameter STEP_EN, default 1: 1 enables single-step mode; 0 ties step mode off.
REQ-004 clock  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous, active-high; clock is clock.
REQ-006 run  in  1  level; 1 = free-run mode.
REQ-007 step  in  1  single-cycle pulse; advances one FSM state when run=0 and STEP_EN=1.
REQ-008 opcode_in  in  27  [22:0] one-hot opcode (bit order NOOP,INPUTC,INPUTCF,INPUTD,INPUTDF,MOVE,LOADI,ADD,ADDI,SUB,SUBI,LOAD,LOADF,STORE,STOREF,SHIFTL,SHIFTR,CMP,JUMP,BRE,BRNE,BRG,BRGE); [26:25] RX; [24:23] RY.
REQ-009 flags_reg  in  4  [0]Z, [1]N, [2]O, [3]C.
REQ-010 c  out  CW  control word c[CW:1].
REQ-011 state_o  out  4  current state encoding per REQ-014.
REQ-012 instr_done  out  1  one-cycle pulse on the final state of each instruction.
REQ-013 retired  out  CNTW  retired-instruction count; illegal_op  out  1  sticky illegal-opcode flag.

Function
REQ-014 States and encoding: IF=0, ID=1, EX_ALU=2, EX_ADDR=3, EX_JUMP=4, EX_LOAD=5, EX_LOADI=6, EX_MOVE=7, EX_LIR=8, EX_SWAP=9, MEM_RD=10, MEM_WR=11, WB_ALU=12, WB_LOAD=13; codes 14-15 are unreachable and SHALL go to IF on the next adv.
REQ-015 adv = run | (STEP_EN & step); the state register SHALL update only when adv=1.
REQ-016 c SHALL be all-zero in any cycle with adv=0; with adv=1, c SHALL be decoded from the current state per REQ-022..REQ-024.
REQ-017 Paths, all starting IF->ID: NOOP and INPUT* ->IF; MOVE ->EX_MOVE->WB_ALU; LOADI ->EX_LOADI->WB_ALU; ADD/SUB/SHIFTL/SHIFTR ->EX_ALU->WB_ALU; ADDI/SUBI ->EX_ADDR->WB_ALU; CMP ->EX_ALU->IF; LOAD ->EX_LOAD->MEM_RD->WB_LOAD; LOADF ->EX_LOAD->WB_ALU->EX_LIR->EX_ALU->MEM_RD->WB_LOAD; STORE ->EX_LOAD->MEM_WR; STOREF ->EX_SWAP->EX_LOADI->MEM_WR; JUMP ->EX_JUMP. Every path ends ->IF.
REQ-018 Branches from ID: BRE taken if Z; BRNE if !Z; BRG if !Z&!N; BRGE if !N. Taken ->EX_JUMP->IF (3 adv cycles); not taken ->IF (2 adv cycles). Flags are sampled in the ID cycle.
REQ-019 Latency in adv cycles: NOOP/INPUT* 2, CMP/JUMP 3, ALU/immediate/MOVE/LOADI/STORE 4, STOREF 5, LOAD 5, LOADF 8.
REQ-020 An opcode_in[22:0] that is zero or multi-hot SHALL be executed as NOOP and SHALL set illegal_op, which is cleared only by reset.
REQ-021 instr_done=1 iff adv=1 and next_state=IF with state!=IF; on that edge retired SHALL increment by 1 and wrap from 2^CNTW-1 to 0.
REQ-022 IF: c3,c12,c16,c20,c22. ID: c3,c11,c12,c15,c22; for MOVE/LOADF/STORE/STOREF {c4,c5,c6,c7}={RY,RX}, otherwise {RX,RY}.
REQ-023 EX_ALU: c14,c21,c22,c24; c12=OR of opcode bits {17,14,12,10:7,5:4,2}; c13=OR of opcode bits {17:16,10:9}. EX_ADDR: same without c21. EX_LOAD: c12,c14,c19,c22,c24. EX_MOVE: c12,c14,c19,c20,c22,c24. EX_LOADI: c12,c19,c22,c24. EX_JUMP: c2,c3.
REQ-024 EX_LIR: c11, {c4,c5}=RX. EX_SWAP: c11,c15, {c6,c7}=RX, {c4,c5}=RY. MEM_RD: c23. MEM_WR: c17. WB_ALU: c10, {c8,c9}=RX. WB_LOAD: c10,c18, {c8,c9}=RX.
REQ-025 If step and run are both 1, the FSM SHALL advance exactly once per clock.

Reset
REQ-026 On reset, mid-instruction or not: state=IF, retired=0, illegal_op=0, instr_done=0, c=0 while reset is asserted; the first adv after release fetches from IF.

Verification
REQ-027 run=1, ADD RX=1 RY=2 -> states 0,1,2,12,0; WB_ALU c10=1, c8=0, c9=1; instr_done pulses once; retired=1.
REQ-028 run=1, BRG with flags=0000 -> states 0,1,4,0; with flags=0001 -> states 0,1,0; retired increments by 1 in each case.
REQ-029 run=1, LOADF -> states 0,1,5,12,8,2,10,13,0 (8 cycles); c23=1 only in the MEM_RD cycle.
REQ-030 run=0, STEP_EN=1, three step pulses spaced 5 cycles apart on STORE -> state advances 0->1->5->11 only on the pulse edges; c=0 between pulses.
REQ-031 opcode_in[22:0]=0 then 0x000180 -> both run as a 2-cycle NOOP; illegal_op=1 stays set until reset.
REQ-032 Assert reset while in MEM_RD of LOAD with retired=0xFFFF -> state=0, retired=0, c=0 immediately; separately, without reset, one more retirement from 0xFFFF -> retired wraps to 0.
